idu_pipe: RTL

//  Registered, parametrised RV32I/RV64I decode stage between IFU and EXU. Accepts {pc,inst}
//  on a valid/ready handshake, decodes in one cycle and holds results in a 2-entry
//  (main + skid) output buffer. Adds XLEN=64 (*W ops, ld/sd/lwu), illegal detection, flush.

---
 rtl/idu_pipe_if.sv | 43 ++++
 rtl/idu_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe_if.sv
// Handshake bundle between IFU, decode stage and EXU.
// master = the side that feeds instructions and consumes decoded bundles; slave = idu_pipe.
interface idu_pipe_if #(
  parameter int unsigned XLEN = 32
) ();
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [XLEN-1:0]   out_imm;
  logic [6:0]        out_opcode;
  logic [2:0]        out_func3;
  logic [9:0]        out_funcEU;
  logic [1:0]        out_amux1;
  logic [1:0]        out_amux2;
  logic              out_wen;
  logic              out_mem_ren;
  logic              out_mem_wen;
  logic [XLEN/8-1:0] out_wmask;
  logic              out_word;
  logic              out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_opcode,
           out_func3, out_funcEU, out_amux1, out_amux2, out_wen, out_mem_ren, out_mem_wen,
           out_wmask, out_word, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_opcode,
           out_func3, out_funcEU, out_amux1, out_amux2, out_wen, out_mem_ren, out_mem_wen,
           out_wmask, out_word, out_illegal
  );
endinterface

// File: rtl/idu_pipe.sv
// RV32I/RV64I decode stage: one-cycle combinational decode into a registered
// main + skid output buffer with valid/ready handshakes on both sides and flush.
module idu_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input logic       clk,
  input logic       rst,
  idu_pipe_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("idu_pipe: XLEN must be 32 or 64");
  end

  localparam int unsigned MW   = XLEN / 8;
  localparam bit          Rv64 = (XLEN == 64);

  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6F;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpImm    = 7'h13;
  localparam logic [6:0] OpImm32  = 7'h1B;
  localparam logic [6:0] OpOp     = 7'h33;
  localparam logic [6:0] OpOp32   = 7'h3B;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [9:0]      funceu;
    logic [1:0]      amux1;
    logic [1:0]      amux2;
    logic            wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [MW-1:0]   wmask;
    logic            word;
    logic            illegal;
  } bundle_t;

  logic [31:0]        inst;
  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;
  logic [7:0]         mask8;
  logic               ill;
  bundle_t            dec;

  assign inst  = bus.in_inst;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = inst[31:20];
  assign imm_s = {inst[31:25], inst[11:7]};
  assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Unshifted store byte mask from the access size in func3.
  always_comb begin
    unique case (f3[1:0])
      2'd0:    mask8 = 8'h01;
      2'd1:    mask8 = 8'h03;
      2'd2:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
  end

  // Decode the incoming instruction into a bundle; illegal kills all side effects.
  always_comb begin
    dec        = '0;
    ill        = 1'b0;
    dec.pc     = bus.in_pc;
    dec.rs1    = inst[19:15];
    dec.rs2    = inst[24:20];
    dec.rd     = inst[11:7];
    dec.opcode = opc;
    dec.func3  = f3;
    case (opc)
      OpLui: begin
        dec.wen = 1'b1; dec.amux2 = 2'd2; dec.imm = XLEN'(imm_u);
      end
      OpAuipc: begin
        dec.wen = 1'b1; dec.amux1 = 2'd2; dec.amux2 = 2'd2; dec.imm = XLEN'(imm_u);
      end
      OpJal: begin
        dec.wen = 1'b1; dec.amux1 = 2'd2; dec.amux2 = 2'd2; dec.imm = XLEN'(imm_j);
      end
      OpJalr: begin
        dec.wen = 1'b1; dec.amux1 = 2'd1; dec.amux2 = 2'd2; dec.imm = XLEN'(imm_i);
      end
      OpBranch: begin
        dec.amux1 = 2'd2; dec.amux2 = 2'd2; dec.imm = XLEN'(imm_b);
      end
      OpLoad: begin
        dec.wen = 1'b1; dec.mem_ren = 1'b1; dec.amux1 = 2'd1; dec.amux2 = 2'd2;
        dec.imm = XLEN'(imm_i);
        if (f3 == 3'd7 || (!Rv64 && (f3 == 3'd3 || f3 == 3'd6))) ill = 1'b1;
      end
      OpStore: begin
        dec.mem_wen = 1'b1; dec.amux1 = 2'd1; dec.amux2 = 2'd2; dec.imm = XLEN'(imm_s);
        dec.wmask = mask8[MW-1:0];
        if (Rv64 ? (f3 > 3'd3) : (f3 > 3'd2)) ill = 1'b1;
      end
      OpImm, OpImm32: begin
        dec.wen = 1'b1; dec.amux1 = 2'd1; dec.amux2 = 2'd2; dec.imm = XLEN'(imm_i);
        dec.word = (opc == OpImm32);
        if (opc == OpImm32 && !Rv64) ill = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          dec.funceu = {f3, inst[31:26], 1'b0};
          if (inst[31:26] != 6'h00 && inst[31:26] != 6'h10) ill = 1'b1;
          // shamt[5] only exists for 64-bit shifts
          if ((!Rv64 || opc == OpImm32) && inst[25]) ill = 1'b1;
        end else begin
          dec.funceu = {f3, 7'b0};
        end
      end
      OpOp, OpOp32: begin
        dec.wen = 1'b1; dec.amux1 = 2'd1; dec.amux2 = 2'd1; dec.funceu = {f3, f7};
        dec.word = (opc == OpOp32);
        if (opc == OpOp32 && !Rv64) ill = 1'b1;
        if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
        if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      dec.wen     = 1'b0;
      dec.mem_ren = 1'b0;
      dec.mem_wen = 1'b0;
      dec.wmask   = '0;
      dec.word    = 1'b0;
    end
    dec.illegal = ill;
  end

  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic    rdy_q;
  logic    acc, cons;

  assign acc  = bus.in_valid & bus.in_ready & ~bus.flush;
  assign cons = main_v_q & bus.out_ready;

  // Buffer next state: skid refills main on consume, new bundles fill the first free slot.
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (bus.flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || cons) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = acc;
        if (acc) skid_d = dec;
      end else begin
        main_v_d = acc;
        if (acc) main_d = dec;
      end
    end else if (acc && SKID != 0) begin
      skid_v_d = 1'b1;
      skid_d   = dec;
    end
  end

  // Buffer state; rdy_q also acts as the out-of-reset flag for SKID=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= ~skid_v_d;
    end
  end

  assign bus.in_ready    = (SKID != 0) ? rdy_q : (rdy_q & (~main_v_q | bus.out_ready));
  assign bus.out_valid   = main_v_q;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_func3   = main_q.func3;
  assign bus.out_funcEU  = main_q.funceu;
  assign bus.out_amux1   = main_q.amux1;
  assign bus.out_amux2   = main_q.amux2;
  assign bus.out_wen     = main_q.wen;
  assign bus.out_mem_ren = main_q.mem_ren;
  assign bus.out_mem_wen = main_q.mem_wen;
  assign bus.out_wmask   = main_q.wmask;
  assign bus.out_word    = main_q.word;
  assign bus.out_illegal = main_q.illegal;

endmodule
